// File: rtl/cpu_types_pkg.sv
// Shared pipeline-control types for the 5-stage core.
package cpu_types_pkg;
  typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT, HALTED} hz_state_t;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10} fwd_sel_t;
endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle of hazard controller signals, same modport style as the stage interfaces.
interface hazard_control_unit_if #(parameter int RSEL_W = 5, parameter int CNT_W = 32);
  logic              ihit, dhit;
  logic [RSEL_W-1:0] dec_rs, dec_rt, ex_rs, ex_rt, ex_wsel, mem_wsel, wb_wsel;
  logic              dec_use_rs, dec_use_rt, ex_MemRd, ex_RegWr, ex_taken;
  logic              mem_MemRd, mem_MemWr, mem_RegWr, wb_RegWr, wb_halt;
  logic              pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en, wb_stall, halted;
  logic [1:0]        fwd_a, fwd_b;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  modport hcu (
    input  ihit, dhit, dec_rs, dec_rt, dec_use_rs, dec_use_rt, ex_rs, ex_rt, ex_MemRd,
           ex_RegWr, ex_wsel, ex_taken, mem_MemRd, mem_MemWr, mem_RegWr, mem_wsel,
           wb_RegWr, wb_wsel, wb_halt,
    output pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en, wb_stall, fwd_a, fwd_b,
           halted, stall_cnt, flush_cnt
  );
  modport tb (
    output ihit, dhit, dec_rs, dec_rt, dec_use_rs, dec_use_rt, ex_rs, ex_rt, ex_MemRd,
           ex_RegWr, ex_wsel, ex_taken, mem_MemRd, mem_MemWr, mem_RegWr, mem_wsel,
           wb_RegWr, wb_wsel, wb_halt,
    input  pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en, wb_stall, fwd_a, fwd_b,
           halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/forwarding_unit.sv
// Execute operand bypass select; memory stage beats writeback, $0 never forwarded.
module forwarding_unit
  import cpu_types_pkg::*;
#(
  parameter int RSEL_W = 5
) (
  input  logic [RSEL_W-1:0] ex_rs,
  input  logic [RSEL_W-1:0] ex_rt,
  input  logic              mem_RegWr,
  input  logic [RSEL_W-1:0] mem_wsel,
  input  logic              wb_RegWr,
  input  logic [RSEL_W-1:0] wb_wsel,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);
  function automatic logic [1:0] pick(
    input logic [RSEL_W-1:0] r,
    input logic mrw, input logic [RSEL_W-1:0] mw,
    input logic wrw, input logic [RSEL_W-1:0] ww
  );
    if (mrw && mw != '0 && mw == r)      return FWD_MEM;
    else if (wrw && ww != '0 && ww == r) return FWD_WB;
    else                                 return FWD_RF;
  endfunction

  assign fwd_a = pick(ex_rs, mem_RegWr, mem_wsel, wb_RegWr, wb_wsel);
  assign fwd_b = pick(ex_rt, mem_RegWr, mem_wsel, wb_RegWr, wb_wsel);
endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline latch sequencing: halt, D-miss freeze, branch flush, load-use bubble, I-miss stall.
module hazard_control_unit
  import cpu_types_pkg::*;
#(
  parameter int RSEL_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [RSEL_W-1:0] dec_rs,
  input  logic [RSEL_W-1:0] dec_rt,
  input  logic              dec_use_rs,
  input  logic              dec_use_rt,
  input  logic [RSEL_W-1:0] ex_rs,
  input  logic [RSEL_W-1:0] ex_rt,
  input  logic              ex_MemRd,
  input  logic              ex_RegWr,
  input  logic [RSEL_W-1:0] ex_wsel,
  input  logic              ex_taken,
  input  logic              mem_MemRd,
  input  logic              mem_MemWr,
  input  logic              mem_RegWr,
  input  logic [RSEL_W-1:0] mem_wsel,
  input  logic              wb_RegWr,
  input  logic [RSEL_W-1:0] wb_wsel,
  input  logic              wb_halt,
  output logic              pc_en,
  output logic              fd_en,
  output logic              fd_flush,
  output logic              de_en,
  output logic              de_flush,
  output logic              em_en,
  output logic              mw_en,
  output logic              wb_stall,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  hz_state_t state, next_state;
  logic      halt_now, dmiss, load_use, flush_inc;

  assign halt_now = (state == HALTED) || wb_halt;
  assign dmiss    = (mem_MemRd || mem_MemWr) && !dhit;
  // LDSTALL masks the check so the same load/consumer pair yields one bubble only
  assign load_use = (state == RUN) && ex_MemRd && ex_RegWr && (ex_wsel != '0) &&
                    ((dec_use_rs && ex_wsel == dec_rs) || (dec_use_rt && ex_wsel == dec_rt));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= next_state;
  end

  always_comb begin
    next_state = RUN;
    if (halt_now)      next_state = HALTED;
    else if (dmiss)    next_state = MEMWAIT;
    else if (ex_taken) next_state = RUN;
    else if (load_use) next_state = LDSTALL;
  end

  always_comb begin
    pc_en = 1'b0; fd_en = 1'b0; de_en = 1'b0; em_en = 1'b0; mw_en = 1'b0;
    fd_flush = 1'b0; de_flush = 1'b0; wb_stall = 1'b0; flush_inc = 1'b0;
    if (!nRST) begin
      // everything held quiet while in reset
    end else if (halt_now || dmiss) begin
      wb_stall = 1'b1;
    end else if (ex_taken) begin
      pc_en = 1'b1; fd_en = 1'b1; de_en = 1'b1; em_en = 1'b1; mw_en = 1'b1;
      fd_flush = 1'b1; de_flush = 1'b1; flush_inc = 1'b1;
    end else if (load_use || !ihit) begin
      de_en = 1'b1; em_en = 1'b1; mw_en = 1'b1; de_flush = 1'b1;
    end else begin
      pc_en = 1'b1; fd_en = 1'b1; de_en = 1'b1; em_en = 1'b1; mw_en = 1'b1;
    end
  end

  assign halted = (state == HALTED);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && stall_cnt != '1)    stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  forwarding_unit #(.RSEL_W(RSEL_W)) u_fwd (
    .ex_rs(ex_rs), .ex_rt(ex_rt),
    .mem_RegWr(mem_RegWr), .mem_wsel(mem_wsel),
    .wb_RegWr(wb_RegWr), .wb_wsel(wb_wsel),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );
endmodule
